pwm_gen: RTL and testbench
==========================

// Module: pwm_gen
// PURPOSE
//  Complementary PWM generator with dead time, downstream of the clock divider.
//  - tick_fast (5MHz enable) drives the PWM counter.
//  - tick_slow (100Hz) arms the generator and gates duty updates.
//  - New duty values arrive over a valid/ready port; they are applied only at a
//    PWM period boundary following a slow tick, so frames stay glitch-free.
// PARAMETERS
//  CNT_W   16   counter/duty width in bits
//  PERIOD  500  PWM period in tick_fast units (10kHz at 5MHz); 2..2**CNT_W-1
//  DEAD    5    dead time in tick_fast units on each edge; DEAD < PERIOD
// PORTS
//  clk_in       in   1      system clock, 50MHz
//  rst_n        in   1      reset, synchronous, active-low
//  en           in   1      run enable
//  tick_fast    in   1      count-enable pulse, one clk_in cycle wide
//  tick_slow    in   1      frame pulse, one clk_in cycle wide
//  duty_in      in   CNT_W  requested high time in tick_fast units
//  duty_valid   in   1      duty_in valid
//  duty_ready   out  1      pending slot free
//  pwm_hi       out  1      high-side drive
//  pwm_lo       out  1      low-side drive
//  period_start out  1      1-cycle pulse at every period start
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk_in):
//   - state=S_IDLE; cnt=0; duty_act=0; pend=0; pend_full=0; sync=0.
//   - pwm_hi=0, pwm_lo=0, period_start=0, duty_ready=1.
//   - Reset mid-operation discards any pending duty.
//  Handshake:
//   - duty_ready = !pend_full.
//   - On valid&&ready: pend <= min(duty_in, PERIOD); pend_full <= 1.
//   - duty_in > PERIOD is clamped to PERIOD.
//   - valid without ready: no effect; the source holds its data.
//  FSM:
//   - S_IDLE: en=1 -> S_ARM.
//   - S_ARM: tick_slow -> S_RUN with cnt=0 and period_start=1.
//     A tick_fast in the same cycle is ignored.
//   - S_RUN: on tick_fast, cnt <= (cnt==PERIOD-1) ? 0 : cnt+1. The wrap
//     raises period_start for 1 cycle.
//   - Any state: en=0 -> S_IDLE next cycle; cnt=0; outputs 0 the cycle after.
//  Duty apply:
//   - tick_slow in S_RUN sets sync.
//   - At wrap: if sync && pend_full, duty_act <= pend and pend_full <= 0.
//     sync <= 0 at every wrap, whether or not a value was applied.
//   - A tick_slow in the wrap cycle sets sync for the next wrap.
//   - Entering S_RUN with pend_full applies pend immediately.
//  Outputs: registered, 1 clk_in of latency from cnt; forced 0 outside S_RUN.
//   - pwm_hi = (cnt >= DEAD) && (cnt < duty_act).
//   - pwm_lo = (cnt >= duty_act+DEAD) && (cnt < PERIOD).
//   - duty_act+DEAD is computed in CNT_W+1 bits; no wrap-around.
//   - pwm_hi and pwm_lo are never both 1.
//   - duty_act=0: pwm_hi stays 0. duty_act >= PERIOD-DEAD: pwm_lo stays 0.
//   - duty_act <= DEAD: pwm_hi stays 0.
//  tick_fast held high counts on every clk_in cycle; this is legal.
// STRUCTURE
//  Package anspwm_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} pwm_state_t.
//   - localparam PWM_CNT_W = 16.
//  Sub-module pwm_dutybuf: valid/ready slot, clamp and pending register,
//  with an apply strobe input.
//  Counter, FSM and output compare stay in pwm_gen.
// TESTING (PERIOD=10, DEAD=2, tick_fast every cycle unless stated)
//  1. rst_n=0 mid-RUN with pend_full=1 -> next cycle all outputs 0,
//     duty_ready=1, state S_IDLE.
//  2. duty 4 loaded, en=1, tick_slow -> pwm_hi=1 for cnt 2..3;
//     pwm_lo=1 for cnt 6..9; period_start every 10 cycles.
//  3. duty_in=15 -> clamped to 10 -> pwm_hi for cnt 2..9; pwm_lo never set.
//  4. New duty 7 mid-frame, no tick_slow -> duty_act keeps the old value.
//     Then tick_slow -> applied at the next wrap; duty_ready=0 until then.
//  5. Second duty_valid while pend_full -> not accepted. tick_slow and wrap
//     in the same cycle -> sync is set and the duty applies one period later.
//  6. en=0 mid-period -> outputs 0 within 2 cycles. Re-enable -> waits in
//     S_ARM until tick_slow, then restarts at cnt=0.

Source files
------------

// File: rtl/anspwm_pkg.sv
// anspwm_pkg: shared FSM state type and default width for the PWM generator
package anspwm_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} pwm_state_t;
    localparam int PWM_CNT_W = 16;
endpackage

// File: rtl/pwm_dutybuf.sv
// pwm_dutybuf: one-entry duty slot with valid/ready intake, clamp to PERIOD and apply strobe
//  i_clk, i_rst_n     clock, synchronous active-low reset
//  i_valid, i_duty    incoming duty request
//  i_apply            consume the pending value (ignored when empty)
//  o_ready            slot free
//  o_pend, o_full     pending value and its occupancy flag
module pwm_dutybuf
    import anspwm_pkg::*;
#(
    parameter int CNT_W  = PWM_CNT_W,
    parameter int PERIOD = 500
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_apply,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_pend,
    output logic             o_full
);
    localparam logic [CNT_W-1:0] P_MAX = CNT_W'(PERIOD);
    logic [CNT_W-1:0] r_pend;
    logic             r_full;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_pend <= (i_duty > P_MAX) ? P_MAX : i_duty;
            r_full <= 1'b1;
        end else if (i_apply) begin
            r_full <= 1'b0;
        end
    end
    assign o_ready = !r_full;
    assign o_pend  = r_pend;
    assign o_full  = r_full;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: complementary PWM with dead time, armed by tick_slow, duty updates applied at period boundaries
//  clk_in, rst_n             clock, synchronous active-low reset
//  en                        run enable
//  tick_fast, tick_slow      counter enable and frame pulses
//  duty_in, duty_valid       duty request, duty_ready when the slot is free
//  pwm_hi, pwm_lo            high/low side drives (registered)
//  period_start              one-cycle pulse at every period start
module pwm_gen
    import anspwm_pkg::*;
#(
    parameter int CNT_W  = PWM_CNT_W,
    parameter int PERIOD = 500,
    parameter int DEAD   = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick_fast,
    input  logic             tick_slow,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start
);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] P_DEAD = CNT_W'(DEAD);
    pwm_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_duty_act, w_pend;
    logic [CNT_W:0]   w_lo_start;
    logic             r_sync, r_hi, r_lo, r_ps;
    logic             w_start, w_wrap, w_apply, w_full, w_ready;
    pwm_dutybuf #(.CNT_W(CNT_W), .PERIOD(PERIOD)) u_buf (
        .i_clk   (clk_in),
        .i_rst_n (rst_n),
        .i_valid (duty_valid),
        .i_duty  (duty_in),
        .i_apply (w_apply),
        .o_ready (w_ready),
        .o_pend  (w_pend),
        .o_full  (w_full)
    );
    always_comb begin
        w_start     = (r_state == S_ARM) && en && tick_slow;
        w_wrap      = (r_state == S_RUN) && en && tick_fast && (r_cnt == P_LAST);
        // entering RUN applies any pending duty at once; later only at a synced wrap
        w_apply     = w_start || (w_wrap && r_sync);
        w_state_nxt = !en ? S_IDLE :
                      (r_state == S_IDLE) ? S_ARM :
                      w_start ? S_RUN :
                      (r_state == S_ARM || r_state == S_RUN) ? r_state : S_IDLE;
        w_cnt_nxt   = (r_state != S_RUN || !en) ? '0 :
                      !tick_fast ? r_cnt :
                      w_wrap ? '0 : r_cnt + CNT_W'(1);
        // widened so duty_act+DEAD cannot wrap when duty_act is near the top of the range
        w_lo_start  = {1'b0, r_duty_act} + {1'b0, P_DEAD};
    end
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_duty_act <= '0;
            r_sync     <= 1'b0;
            r_hi       <= 1'b0;
            r_lo       <= 1'b0;
            r_ps       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ps    <= w_start || w_wrap;
            if (w_apply && w_full)
                r_duty_act <= w_pend;
            // a tick_slow landing on the wrap arms the following wrap
            r_sync  <= (w_state_nxt != S_RUN) ? 1'b0 :
                       w_wrap ? tick_slow :
                       (tick_slow && r_state == S_RUN) ? 1'b1 : r_sync;
            r_hi    <= (r_state == S_RUN) && (r_cnt >= P_DEAD) && (r_cnt < r_duty_act);
            r_lo    <= (r_state == S_RUN) && ({1'b0, r_cnt} >= w_lo_start) && (r_cnt < P_MAX);
        end
    end
    assign duty_ready   = w_ready;
    assign pwm_hi       = r_hi;
    assign pwm_lo       = r_lo;
    assign period_start = r_ps;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: vector table, corner sequences and randomized run against a reference model
module tb_pwm_gen;
    localparam int P = 10;
    localparam int D = 2;
    localparam int W = 16;

    logic         clk_in = 1'b0;
    logic         rst_n = 1'b0, en = 1'b0, tick_fast = 1'b0, tick_slow = 1'b0, duty_valid = 1'b0;
    logic [W-1:0] duty_in = '0;
    logic         duty_ready, pwm_hi, pwm_lo, period_start;

    pwm_gen #(.CNT_W(W), .PERIOD(P), .DEAD(D)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .en           (en),
        .tick_fast    (tick_fast),
        .tick_slow    (tick_slow),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;
    int c_hi = 0, c_lo = 0;

    // reference model: mode 0 idle, 1 armed, 2 running; pos is the position in the period
    int  m_mode = 0, m_pos = 0, m_duty = 0;
    bit  m_sync = 0;
    int  m_pend[$];
    bit  e_hi = 0, e_lo = 0, e_ps = 0, e_rdy = 1;

    typedef struct {
        bit r, e, tf, ts, v;
        int d;
        bit hi, lo, ps, rdy;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_n(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit had, wrap, start, osync;
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_duty = 0; m_sync = 0;
            m_pend.delete();
            e_hi = 0; e_lo = 0; e_ps = 0; e_rdy = 1;
            return;
        end
        e_hi  = (m_mode == 2) && m_pos >= D && m_pos < m_duty;
        e_lo  = (m_mode == 2) && m_pos >= m_duty + D && m_pos < P;
        had   = m_pend.size() != 0;
        wrap  = 0;
        start = 0;
        osync = m_sync;
        if (!en) begin
            m_mode = 0; m_pos = 0; m_sync = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (tick_slow) begin
                m_mode = 2; m_pos = 0; start = 1; m_sync = 0;
            end
        end else begin
            if (tick_fast) begin
                if (m_pos == P - 1) begin
                    wrap = 1; m_pos = 0;
                end else m_pos++;
            end
            if (wrap) m_sync = tick_slow;
            else if (tick_slow) m_sync = 1;
        end
        e_ps = start || wrap;
        if (had && (start || (wrap && osync))) m_duty = m_pend.pop_front();
        if (!had && duty_valid) m_pend.push_back(int'(duty_in) > P ? P : int'(duty_in));
        e_rdy = m_pend.size() == 0;
    endtask

    task automatic cyc(input bit r, input bit e, input bit tf, input bit ts, input int d, input bit v);
        @(negedge clk_in);
        rst_n = r; en = e; tick_fast = tf; tick_slow = ts; duty_in = W'(d); duty_valid = v;
        model_step();
        @(posedge clk_in);
        #1;
        chk("pwm_hi", pwm_hi, e_hi);
        chk("pwm_lo", pwm_lo, e_lo);
        chk("period_start", period_start, e_ps);
        chk("duty_ready", duty_ready, e_rdy);
        c_hi += int'(pwm_hi);
        c_lo += int'(pwm_lo);
    endtask

    task automatic run_to_wrap(input bit ts_at_wrap);
        int n = 0;
        while (!(m_mode == 2 && m_pos == P - 1) && n < 50) begin
            cyc(1, 1, 1, 0, 0, 0);
            n++;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL wrap_timeout: no wrap within 50 cycles");
        end
        cyc(1, 1, 1, ts_at_wrap, 0, 0);
        chk("wrap_pulse", period_start, 1'b1);
    endtask

    task automatic one_period(input string nm, input int exp_hi, input int exp_lo);
        c_hi = 0;
        c_lo = 0;
        repeat (P) cyc(1, 1, 1, 0, 0, 0);
        chk_n({nm, "_hi_count"}, c_hi, exp_hi);
        chk_n({nm, "_lo_count"}, c_lo, exp_lo);
    endtask

    initial begin
        //          r  e  tf ts v  d   hi lo ps rdy
        tbl[0]  = '{0, 0, 1, 0, 0, 0,  0, 0, 0, 1};
        tbl[1]  = '{1, 0, 1, 0, 1, 4,  0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 1, 0, 0,  0, 0, 1, 1};
        tbl[4]  = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 1};
        tbl[5]  = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 1};
        tbl[6]  = '{1, 1, 1, 0, 0, 0,  1, 0, 0, 1};
        tbl[7]  = '{1, 1, 1, 0, 0, 0,  1, 0, 0, 1};
        tbl[8]  = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 1};
        tbl[9]  = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 1};
        tbl[10] = '{1, 1, 1, 0, 0, 0,  0, 1, 0, 1};
        tbl[11] = '{1, 1, 1, 0, 0, 0,  0, 1, 0, 1};
        tbl[12] = '{1, 1, 1, 0, 0, 0,  0, 1, 0, 1};
        tbl[13] = '{1, 1, 1, 0, 0, 0,  0, 1, 1, 1};
        tbl[14] = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 1};
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].tf, tbl[i].ts, tbl[i].d, tbl[i].v);
            chk($sformatf("tbl%0d_hi", i), pwm_hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), pwm_lo, tbl[i].lo);
            chk($sformatf("tbl%0d_ps", i), period_start, tbl[i].ps);
            chk($sformatf("tbl%0d_rdy", i), duty_ready, tbl[i].rdy);
        end

        // clamp: 15 becomes 10, high from cnt 2..9, low never
        cyc(1, 1, 1, 0, 15, 1);
        chk("clamp_ready_low", duty_ready, 1'b0);
        cyc(1, 1, 1, 1, 0, 0);
        run_to_wrap(0);
        chk("clamp_applied_ready", duty_ready, 1'b1);
        one_period("clamp", 8, 0);

        // new duty without tick_slow stays pending
        cyc(1, 1, 1, 0, 7, 1);
        chk("hold_ready_low", duty_ready, 1'b0);
        run_to_wrap(0);
        one_period("hold", 8, 0);
        chk("hold_still_pending", duty_ready, 1'b0);
        cyc(1, 1, 1, 1, 0, 0);
        run_to_wrap(0);
        chk("apply7_ready", duty_ready, 1'b1);
        one_period("duty7", 5, 1);

        // second valid while full is refused; tick_slow on the wrap defers by one period
        cyc(1, 1, 1, 0, 3, 1);
        cyc(1, 1, 1, 0, 1, 1);
        chk("refuse_ready_low", duty_ready, 1'b0);
        run_to_wrap(1);
        chk("defer_ready_low", duty_ready, 1'b0);
        one_period("defer", 5, 1);
        chk("defer_applied_ready", duty_ready, 1'b1);
        one_period("duty3", 1, 5);

        // disable mid-period, then re-arm
        repeat (4) cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("dis_hi", pwm_hi, 1'b0);
        chk("dis_lo", pwm_lo, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 1, 0, 0, 0);
            chk("arm_wait_ps", period_start, 1'b0);
            chk("arm_wait_hi", pwm_hi, 1'b0);
            chk("arm_wait_lo", pwm_lo, 1'b0);
        end
        cyc(1, 1, 1, 1, 0, 0);
        chk("rearm_ps", period_start, 1'b1);
        one_period("rearm", 1, 5);

        // reset mid-run discards the pending duty
        repeat (3) cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 6, 1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("rst_hi", pwm_hi, 1'b0);
        chk("rst_lo", pwm_lo, 1'b0);
        chk("rst_ps", period_start, 1'b0);
        chk("rst_ready", duty_ready, 1'b1);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        one_period("after_rst", 0, 8);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 19) != 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
